csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_alu.sv | 22 ++
 rtl/csr_access_unit.sv | 136 +++++++++++++
 tb/tb_csr_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the CSR access unit.
//   - funct3 encodings of the six Zicsr instructions
//   - FSM state enum
//   - addresses of the free-running read-only counters
//   - CSR_IMPL_MASK: address bits that must be zero for an implemented CSR
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [11:0] CSR_WRONG_BRANCH = 12'h000;
    localparam logic [11:0] CSR_CONTROL_XFER = 12'h001;
    localparam logic [11:0] CSR_VALID_INST   = 12'h002;

    localparam logic [11:0] CSR_IMPL_MASK = 12'hFF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_state_e;

    // Counters advance on their own; software may read them but never write.
    function automatic logic is_counter(input logic [11:0] addr);
        return (addr == CSR_WRONG_BRANCH) || (addr == CSR_CONTROL_XFER) ||
               (addr == CSR_VALID_INST);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational read-modify-write datapath.
//   op     : funct3[1:0] (01 write, 10 set bits, 11 clear bits)
//   oldVal : CSR value read in the READ cycle
//   srcVal : rs1 value or zero-extended immediate
//   newVal : value to write back
module csr_alu (
    input  logic [1:0]  op,
    input  logic [31:0] oldVal,
    input  logic [31:0] srcVal,
    output logic [31:0] newVal
);

    always_comb begin
        newVal = srcVal;
        case (op)
            2'b10:   newVal = oldVal | srcVal;
            2'b11:   newVal = oldVal & ~srcVal;
            default: newVal = srcVal;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction at a time against a
// 16-entry CSR file with a combinational read port and a write port.
//   req*         : request handshake + decoded instruction fields
//   resp*        : response handshake, old CSR value for rd, illegal flag
//   csrReadAddr  : CSR file read address (non-zero only in READ)
//   csr          : CSR file read data
//   csrW*        : CSR file write port (active only in WRITE)
// Legal ops walk IDLE->READ->WRITE->RESP; illegal ops go straight to RESP.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int regSize = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqFunct3,
    input  logic [11:0] reqAddr,
    input  logic [31:0] reqSrc,
    input  logic [4:0]  reqZimm,
    input  logic        reqRs1Zero,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respIllegal,
    output logic [3:0]  csrReadAddr,
    input  logic [31:0] csr,
    output logic        csrWEn,
    output logic [31:0] csrWData,
    output logic [11:0] csrWAddr
);

    localparam int AW = $clog2(regSize);

    csr_state_e state, stateNext;

    logic [1:0]  opQ;
    logic [11:0] addrQ;
    logic [31:0] srcQ;
    logic        wneedQ;
    logic        illegalQ;
    logic [31:0] oldQ;
    logic [31:0] aluOut;

    logic        accept;
    logic        wneedIn;
    logic        illegalIn;
    logic [31:0] srcIn;

    assign accept = reqValid && (state == IDLE);
    assign srcIn  = reqFunct3[2] ? {27'd0, reqZimm} : reqSrc;

    // Set/clear with a zero operand is a pure read and must not touch the CSR.
    always_comb begin
        wneedIn = 1'b0;
        case (reqFunct3)
            F3_RW, F3_RWI:  wneedIn = 1'b1;
            F3_RS, F3_RC:   wneedIn = !reqRs1Zero;
            F3_RSI, F3_RCI: wneedIn = (reqZimm != 5'd0);
            default:        wneedIn = 1'b0;
        endcase
    end

    assign illegalIn = (reqFunct3[1:0] == 2'b00) ||
                       ((reqAddr & CSR_IMPL_MASK) != 12'd0) ||
                       (wneedIn && is_counter(reqAddr));

    csr_alu u_alu (
        .op     (opQ),
        .oldVal (oldQ),
        .srcVal (srcQ),
        .newVal (aluOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opQ      <= 2'd0;
            addrQ    <= 12'd0;
            srcQ     <= 32'd0;
            wneedQ   <= 1'b0;
            illegalQ <= 1'b0;
            oldQ     <= 32'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opQ      <= reqFunct3[1:0];
                addrQ    <= reqAddr;
                srcQ     <= srcIn;
                wneedQ   <= wneedIn;
                illegalQ <= illegalIn;
                oldQ     <= 32'd0;   // illegal responses report zero
            end
            if (state == READ) begin
                oldQ <= csr;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        reqReady    = 1'b0;
        respValid   = 1'b0;
        respData    = 32'd0;
        respIllegal = 1'b0;
        csrReadAddr = 4'd0;
        csrWEn      = 1'b0;
        csrWData    = 32'd0;
        csrWAddr    = 12'd0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) stateNext = illegalIn ? RESP : READ;
            end
            READ: begin
                csrReadAddr = addrQ[AW-1:0];
                stateNext   = WRITE;
            end
            WRITE: begin
                csrWEn    = wneedQ;
                csrWData  = aluOut;
                csrWAddr  = addrQ;
                stateNext = RESP;
            end
            RESP: begin
                respValid   = 1'b1;
                respData    = oldQ;
                respIllegal = illegalQ;
                if (respReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [2:0]  reqFunct3 = 3'd0;
    logic [11:0] reqAddr = 12'd0;
    logic [31:0] reqSrc = 32'd0;
    logic [4:0]  reqZimm = 5'd0;
    logic        reqRs1Zero = 1'b0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] respData;
    logic        respIllegal;
    logic [3:0]  csrReadAddr;
    logic [31:0] csr;
    logic        csrWEn;
    logic [31:0] csrWData;
    logic [11:0] csrWAddr;

    int checks = 0;
    int errors = 0;

    // Environment: CSR file written only by the DUT, counters free-running.
    logic [31:0] regs [16] = '{default: 32'd0};
    logic [31:0] cyc = 32'd0;
    // Reference model's view of the implemented CSRs.
    logic [31:0] refRegs [16] = '{default: 32'd0};

    function automatic logic [31:0] cntv(input logic [3:0] i, input logic [31:0] c);
        return c * ({28'd0, i} + 32'd1) + 32'h100 * {28'd0, i};
    endfunction

    assign csr = (csrReadAddr < 4'd3) ? cntv(csrReadAddr, cyc) : regs[csrReadAddr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (csrWEn && csrWAddr >= 12'd3 && csrWAddr < 12'd16) regs[csrWAddr[3:0]] <= csrWData;
    end

    csr_access_unit #(.regSize(16)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqFunct3(reqFunct3),
        .reqAddr(reqAddr), .reqSrc(reqSrc), .reqZimm(reqZimm), .reqRs1Zero(reqRs1Zero),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .respIllegal(respIllegal), .csrReadAddr(csrReadAddr), .csr(csr),
        .csrWEn(csrWEn), .csrWData(csrWData), .csrWAddr(csrWAddr)
    );

    // One instruction, checked cycle by cycle against the instruction-level rules.
    // Entered and left at #1 after a rising edge.
    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                          input logic [4:0] z, input logic r0, input int hold);
        logic        wn, illegal, expWen;
        logic [31:0] src, expOld, newVal, rcyc;
        int          k, held, lat;
        bit          done;
        case (f3)
            3'd1, 3'd5: wn = 1'b1;
            3'd2, 3'd3: wn = !r0;
            3'd6, 3'd7: wn = (z != 5'd0);
            default:    wn = 1'b0;
        endcase
        illegal = (f3 == 3'd0) || (f3 == 3'd4) || (a > 12'd15) || (wn && a < 12'd3);
        src = f3[2] ? {27'd0, z} : s;

        reqValid = 1'b1; reqFunct3 = f3; reqAddr = a; reqSrc = s; reqZimm = z; reqRs1Zero = r0;
        respReady = 1'b0;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", reqReady); end
        @(posedge clk); #1;
        reqValid = 1'b0; reqFunct3 = 3'($urandom); reqAddr = 12'($urandom); reqSrc = $urandom;
        rcyc = cyc;
        if (illegal)     expOld = 32'd0;
        else if (a < 3)  expOld = cntv(a[3:0], rcyc);
        else             expOld = refRegs[a[3:0]];
        case (f3[1:0])
            2'b10:   newVal = expOld | src;
            2'b11:   newVal = expOld & ~src;
            default: newVal = src;
        endcase
        lat = illegal ? 1 : 3;
        k = 1; held = 0; done = 0;
        while (!done && k < 40) begin
            expWen = !illegal && wn && (k == 2);
            checks++;
            if (csrWEn !== expWen) begin errors++; $display("FAIL wen k=%0d: got %b want %b", k, csrWEn, expWen); end
            checks++;
            if (csrReadAddr !== ((!illegal && k == 1) ? a[3:0] : 4'd0)) begin
                errors++; $display("FAIL read_addr k=%0d: got %h", k, csrReadAddr);
            end
            if (expWen) begin
                checks++;
                if (csrWData !== newVal || csrWAddr !== a) begin
                    errors++; $display("FAIL wdata: got %h@%h want %h@%h", csrWData, csrWAddr, newVal, a);
                end
            end
            checks++;
            if (respValid !== (k >= lat)) begin errors++; $display("FAIL resp_valid k=%0d: got %b", k, respValid); end
            if (k >= lat) begin
                checks++;
                if (respData !== expOld || respIllegal !== illegal || reqReady !== 1'b0) begin
                    errors++;
                    $display("FAIL resp k=%0d: data %h ill %b rdy %b want %h %b 0", k, respData, respIllegal, reqReady, expOld, illegal);
                end
                if (held == hold) begin
                    respReady = 1'b1;
                    @(posedge clk); #1;
                    respReady = 1'b0;
                    checks++;
                    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
                        errors++; $display("FAIL after_hs: valid %b ready %b want 0 1", respValid, reqReady);
                    end
                    done = 1;
                end else held++;
            end
            if (!done) begin @(posedge clk); #1; k++; end
        end
        if (!done) begin errors++; $display("FAIL timeout: no response handshake"); end
        if (!illegal && wn) refRegs[a[3:0]] = newVal;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reqReady !== 1'b1 || respValid !== 1'b0 || respData !== 32'd0 || respIllegal !== 1'b0 ||
            csrWEn !== 1'b0 || csrWData !== 32'd0 || csrWAddr !== 12'd0 || csrReadAddr !== 4'd0) begin
            errors++;
            $display("FAIL reset: rdy %b v %b d %h il %b we %b wd %h wa %h ra %h", reqReady, respValid,
                     respData, respIllegal, csrWEn, csrWData, csrWAddr, csrReadAddr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rw();
        do_req(3'b001, 12'h005, 32'h00000012, 5'd0, 1'b0, 0);
        do_req(3'b001, 12'h005, 32'hDEADBEEF, 5'd0, 1'b0, 0);
        do_req(3'b010, 12'h005, 32'h0, 5'd0, 1'b1, 0);
    endtask

    task automatic test_set_clear();
        do_req(3'b001, 12'h006, 32'h000000F0, 5'd0, 1'b0, 0);
        do_req(3'b010, 12'h006, 32'h0000000F, 5'd0, 1'b0, 0);
        do_req(3'b111, 12'h006, 32'hFFFFFFFF, 5'h10, 1'b0, 0);
        do_req(3'b110, 12'h006, 32'h0, 5'd0, 1'b0, 0);
    endtask

    task automatic test_counters();
        do_req(3'b010, 12'h001, 32'h1234, 5'd0, 1'b1, 0);
        do_req(3'b110, 12'h002, 32'h0, 5'd0, 1'b0, 1);
        do_req(3'b011, 12'h000, 32'h0, 5'd0, 1'b1, 0);
    endtask

    task automatic test_illegal();
        do_req(3'b001, 12'h000, 32'h55, 5'd0, 1'b0, 0);
        do_req(3'b100, 12'h007, 32'h55, 5'd3, 1'b0, 0);
        do_req(3'b000, 12'h007, 32'h55, 5'd3, 1'b0, 0);
        do_req(3'b010, 12'h010, 32'h55, 5'd0, 1'b1, 0);
        do_req(3'b101, 12'h002, 32'h0, 5'd0, 1'b0, 2);
    endtask

    task automatic test_backpressure();
        do_req(3'b001, 12'h009, 32'hA5A5A5A5, 5'd0, 1'b0, 5);
        do_req(3'b011, 12'h009, 32'h000000FF, 5'd0, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_req(3'b001, 12'(10 + i % 3), $urandom, 5'd0, 1'b0, 0);
    endtask

    task automatic test_reset_in_write();
        do_req(3'b001, 12'h007, 32'h11111111, 5'd0, 1'b0, 0);
        reqValid = 1'b1; reqFunct3 = 3'b001; reqAddr = 12'h007; reqSrc = 32'h77777777;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (csrWEn !== 1'b1) begin errors++; $display("FAIL pre_reset_wen: got %b want 1", csrWEn); end
        rst = 1'b1;
        #1;
        checks++;
        if (csrWEn !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++; $display("FAIL async_reset: wen %b valid %b ready %b", csrWEn, respValid, reqReady);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (csrWEn !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b1) begin
                errors++; $display("FAIL post_reset %0d: wen %b valid %b ready %b", i, csrWEn, respValid, reqReady);
            end
        end
        // Aborted write must not have landed.
        do_req(3'b010, 12'h007, 32'h0, 5'd0, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [11:0] a;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) a = 12'h010 | 12'($urandom);
            else                           a = 12'($urandom_range(0, 15));
            do_req(3'($urandom), a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_set_clear();
        test_counters();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_in_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
